barrel_shifter_pipe: RTL

Parametrised, pipelined successor to the 32-bit combinational barrel shifter. Shifts or rotates a WIDTH-bit word by 0..WIDTH-1 positions, with one registered pipeline stage per log2 shift layer. Operands are accepted with a valid/ready handshake, and a carry-out flag reports the last bit shifted out. It sits between the ALU operand mux and the writeback register and sustains one operation per cycle under backpressure.

---
 rtl/shifter_pkg.sv | 24 ++
 rtl/shift_stage.sv | 78 +++++++
 rtl/barrel_shifter_pipe.sv | 70 +++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared mode encodings and decode helpers for the pipelined barrel shifter.
package shifter_pkg;

  localparam logic [2:0] ALU_SRA = 3'b000;
  localparam logic [2:0] ALU_SLA = 3'b001;
  localparam logic [2:0] ALU_SRL = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_ROR = 3'b100;
  localparam logic [2:0] ALU_ROL = 3'b101;

  // 110/111 alias the rotates, so bit 0 alone selects the direction.
  function automatic logic is_left(input logic [2:0] aluc);
    return aluc[0];
  endfunction

  function automatic logic is_rotate(input logic [2:0] aluc);
    return aluc[2];
  endfunction

  function automatic logic is_arith(input logic [2:0] aluc);
    return aluc == ALU_SRA;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One log2 shift layer: conditional shift/rotate by SH, carry update, and a
// stage register that holds while its advance enable is low.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned  WIDTH = 32,
  parameter int unsigned  SH    = 1,
  localparam int unsigned SHW   = $clog2(WIDTH),
  localparam int unsigned K     = $clog2(SH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_b,
  input  logic [2:0]       in_aluc,
  input  logic             in_carry,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_b,
  output logic [2:0]       out_aluc,
  output logic             out_carry
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [SHW-1:0]   b_d, b_q;
  logic [2:0]       aluc_d, aluc_q;
  logic             carry_d, carry_q;

  // Carry tracks the bit that leaves the word last; rotates never report one.
  always_comb begin
    valid_d = in_valid;
    data_d  = in_data;
    b_d     = in_b;
    aluc_d  = in_aluc;
    carry_d = in_carry;
    if (in_b[K]) begin
      if (is_rotate(in_aluc)) begin
        carry_d = 1'b0;
        data_d  = is_left(in_aluc)
                ? {in_data[WIDTH-SH-1:0], in_data[WIDTH-1:WIDTH-SH]}
                : {in_data[SH-1:0], in_data[WIDTH-1:SH]};
      end else if (is_left(in_aluc)) begin
        data_d  = in_data << SH;
        carry_d = in_data[WIDTH-SH];
      end else begin
        data_d  = is_arith(in_aluc) ? WIDTH'($signed(in_data) >>> SH)
                                    : (in_data >> SH);
        carry_d = in_data[SH-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      b_q     <= '0;
      aluc_q  <= '0;
      carry_q <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      b_q     <= b_d;
      aluc_q  <= aluc_d;
      carry_q <= carry_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_b     = b_q;
  assign out_aluc  = aluc_q;
  assign out_carry = carry_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one registered stage per shift layer, with a
// valid/ready advance chain that sustains one operation per cycle.
module barrel_shifter_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned  WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  input  logic [2:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry
);

  localparam int unsigned L = SHW;

  // Index 0 is the operand port; index k+1 is the output of stage k.
  logic [L:0]            stg_valid;
  logic [L:0][WIDTH-1:0] stg_data;
  logic [L:0][SHW-1:0]   stg_b;
  logic [L:0][2:0]       stg_aluc;
  logic [L:0]            stg_carry;
  logic [L-1:0]          adv;
  logic                  unused_tail;

  assign stg_valid[0] = in_valid;
  assign stg_data[0]  = a;
  assign stg_b[0]     = b;
  assign stg_aluc[0]  = aluc;
  assign stg_carry[0] = 1'b0;

  for (genvar k = 0; k < L; k++) begin : g_stage
    // A stage moves if the consumer takes a result or any stage from here
    // to the output is empty.
    assign adv[k] = out_ready || !(&stg_valid[L:k+1]);

    shift_stage #(
      .WIDTH (WIDTH),
      .SH    (32'(1) << k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (adv[k]),
      .in_valid  (stg_valid[k]),
      .in_data   (stg_data[k]),
      .in_b      (stg_b[k]),
      .in_aluc   (stg_aluc[k]),
      .in_carry  (stg_carry[k]),
      .out_valid (stg_valid[k+1]),
      .out_data  (stg_data[k+1]),
      .out_b     (stg_b[k+1]),
      .out_aluc  (stg_aluc[k+1]),
      .out_carry (stg_carry[k+1])
    );
  end

  assign in_ready    = adv[0];
  assign out_valid   = stg_valid[L];
  assign c           = stg_data[L];
  assign carry       = stg_carry[L];
  assign unused_tail = ^{stg_b[L], stg_aluc[L]};

endmodule
